// File: rtl/hub75_scan_reader.sv
// hub75_scan_reader: scans the upper/lower half-frame memories and drives a
// 64x64 HUB75 panel with binary-coded-modulation bitplanes.
// Optional feature: define HUB75_GAMMA_EN to pass each 4-bit colour channel
// through a fixed gamma LUT before plane-bit selection (linear otherwise).
//
// All outputs are registered. The read for a column is issued one cycle ahead
// (from the previous S_CLK, or from the end of S_SHOW), so rdata is valid while
// the FSM sits in S_DATA. Colour bits are visible from S_CLK onward and sclk
// rises one cycle later, giving a full cycle of setup before each shift edge.
// After reset, S_ADDR spends one extra cycle issuing the first read itself.
module hub75_scan_reader #(
    parameter int unsigned NUM_COLS   = 64,
    parameter int unsigned HALF_ROWS  = 32,
    parameter int unsigned BITPLANES  = 4,
    parameter int unsigned DELAY_BASE = 64,
    localparam int unsigned COL_W     = $clog2(NUM_COLS),
    localparam int unsigned ROW_W     = $clog2(HALF_ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [11:0]            rdata0_i,
    input  logic [11:0]            rdata1_i,
    output logic [ROW_W+COL_W-1:0] rd_addr_o,
    output logic                   rd_en_o,
    output logic                   r0_o,
    output logic                   g0_o,
    output logic                   b0_o,
    output logic                   r1_o,
    output logic                   g1_o,
    output logic                   b1_o,
    output logic                   sclk_o,
    output logic                   latch_o,
    output logic                   oe_n_o,
    output logic [ROW_W-1:0]       row_addr_o,
    output logic                   frame_done_o
);

    localparam int unsigned PLANE_W  = 2;
    localparam int unsigned DISP_MAX = DELAY_BASE << (BITPLANES - 1);
    localparam int unsigned DISP_W   = $clog2(DISP_MAX + 1);
    localparam int unsigned ADDR_W   = ROW_W + COL_W;

    localparam logic [1:0]         BIT_OFS    = 2'(4 - BITPLANES);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BITPLANES - 1);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(HALF_ROWS - 1);

    typedef enum logic [2:0] {
        S_ADDR,
        S_DATA,
        S_CLK,
        S_BLANK,
        S_LATCH,
        S_SHOW
    } state_t;

    state_t              state_q;
    logic [COL_W-1:0]    col_q;
    logic [ROW_W-1:0]    row_q;
    logic [PLANE_W-1:0]  plane_q;
    logic [DISP_W-1:0]   disp_cnt_q;

    logic [ADDR_W-1:0]   rd_addr_q;
    logic                rd_en_q;
    logic [5:0]          rgb_q;
    logic                sclk_q;
    logic                latch_q;
    logic                oe_n_q;
    logic [ROW_W-1:0]    row_addr_q;
    logic                frame_done_q;

    // Per-channel intensity mapping ahead of bitplane selection.
    function automatic logic [3:0] chan_map(input logic [3:0] v);
`ifdef HUB75_GAMMA_EN
        case (v)
            4'd0, 4'd1, 4'd2, 4'd3: chan_map = 4'd0;
            4'd4, 4'd5, 4'd6:       chan_map = 4'd1;
            4'd7, 4'd8:             chan_map = 4'd2;
            4'd9:                   chan_map = 4'd3;
            4'd10:                  chan_map = 4'd4;
            4'd11:                  chan_map = 4'd5;
            4'd12:                  chan_map = 4'd7;
            4'd13:                  chan_map = 4'd9;
            4'd14:                  chan_map = 4'd12;
            default:                chan_map = 4'd15;
        endcase
`else
        chan_map = v;
`endif
    endfunction

    logic [1:0]        bit_idx_d;
    logic [3:0]        r0_nib_d, g0_nib_d, b0_nib_d;
    logic [3:0]        r1_nib_d, g1_nib_d, b1_nib_d;
    logic [5:0]        rgb_d;
    logic [COL_W-1:0]  col_inc_d;
    logic [ROW_W-1:0]  row_inc_d;
    logic [ROW_W-1:0]  show_row_d;
    logic [PLANE_W-1:0] show_plane_d;
    logic [DISP_W-1:0] disp_len_d;
    logic              disp_last_d;

    // Plane-bit extraction from the current read data.
    always_comb begin
        bit_idx_d = BIT_OFS + plane_q;
        r0_nib_d  = chan_map(rdata0_i[11:8]);
        g0_nib_d  = chan_map(rdata0_i[7:4]);
        b0_nib_d  = chan_map(rdata0_i[3:0]);
        r1_nib_d  = chan_map(rdata1_i[11:8]);
        g1_nib_d  = chan_map(rdata1_i[7:4]);
        b1_nib_d  = chan_map(rdata1_i[3:0]);
        rgb_d     = {r0_nib_d[bit_idx_d], g0_nib_d[bit_idx_d], b0_nib_d[bit_idx_d],
                     r1_nib_d[bit_idx_d], g1_nib_d[bit_idx_d], b1_nib_d[bit_idx_d]};
    end

    // Scan position successors and display-window length for the current plane.
    always_comb begin
        col_inc_d    = col_q + 1'b1;
        row_inc_d    = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        show_row_d   = (plane_q == LAST_PLANE) ? row_inc_d : row_q;
        show_plane_d = (plane_q == LAST_PLANE) ? '0 : plane_q + 1'b1;
        disp_len_d   = DISP_W'(DELAY_BASE) << plane_q;
        disp_last_d  = (disp_cnt_q == disp_len_d - DISP_W'(1));
    end

    // Scan FSM with registered panel and memory outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_ADDR;
            col_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            disp_cnt_q   <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            rgb_q        <= '0;
            sclk_q       <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            latch_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_ADDR: begin
                    sclk_q <= 1'b0;
                    oe_n_q <= 1'b1;
                    if (rd_en_q) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DATA;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= {row_q, col_q};
                    end
                end
                S_DATA: begin
                    rd_en_q <= 1'b0;
                    rgb_q   <= rgb_d;
                    state_q <= S_CLK;
                end
                S_CLK: begin
                    sclk_q <= 1'b1;
                    if (col_q == LAST_COL) begin
                        col_q   <= '0;
                        state_q <= S_BLANK;
                    end else begin
                        col_q     <= col_inc_d;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= {row_q, col_inc_d};
                        state_q   <= S_ADDR;
                    end
                end
                S_BLANK: begin
                    sclk_q  <= 1'b0;
                    oe_n_q  <= 1'b1;
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    latch_q    <= 1'b1;
                    row_addr_q <= row_q;
                    disp_cnt_q <= '0;
                    state_q    <= S_SHOW;
                end
                S_SHOW: begin
                    oe_n_q <= 1'b0;
                    if (disp_last_d) begin
                        disp_cnt_q <= '0;
                        plane_q    <= show_plane_d;
                        row_q      <= show_row_d;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= {show_row_d, COL_W'(0)};
                        if (plane_q == LAST_PLANE && row_q == LAST_ROW) begin
                            frame_done_q <= 1'b1;
                        end
                        state_q <= S_ADDR;
                    end else begin
                        disp_cnt_q <= disp_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_ADDR;
            endcase
        end
    end

    assign rd_addr_o    = rd_addr_q;
    assign rd_en_o      = rd_en_q;
    assign r0_o         = rgb_q[5];
    assign g0_o         = rgb_q[4];
    assign b0_o         = rgb_q[3];
    assign r1_o         = rgb_q[2];
    assign g1_o         = rgb_q[1];
    assign b1_o         = rgb_q[0];
    assign sclk_o       = sclk_q;
    assign latch_o      = latch_q;
    assign oe_n_o       = oe_n_q;
    assign row_addr_o   = row_addr_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Directed bench for hub75_scan_reader with BITPLANES=4, DELAY_BASE=4 and a
// behavioural pair of 1-cycle synchronous-read half-frame memories.
module tb_hub75_scan_reader;

    logic        clk;
    logic        reset;
    logic [11:0] rdata0, rdata1;
    logic [10:0] rd_addr;
    logic        rd_en;
    logic        r0, g0, b0, r1, g1, b1;
    logic        sclk, latch, oe_n;
    logic [4:0]  row_addr;
    logic        frame_done;

    logic [11:0] mem0 [2048];
    logic [11:0] mem1 [2048];

    int pass_cnt;
    int total_cnt;

    // Results of the most recent capture_unit call.
    logic [5:0] cap [64];
    int n_sclk, n_latch, win_len, row_during, overlap_cnt, unstable_cnt;
    logic timeout;

    hub75_scan_reader #(
        .NUM_COLS  (64),
        .HALF_ROWS (32),
        .BITPLANES (4),
        .DELAY_BASE(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rdata0_i    (rdata0),
        .rdata1_i    (rdata1),
        .rd_addr_o   (rd_addr),
        .rd_en_o     (rd_en),
        .r0_o        (r0),
        .g0_o        (g0),
        .b0_o        (b0),
        .r1_o        (r1),
        .g1_o        (g1),
        .b1_o        (b1),
        .sclk_o      (sclk),
        .latch_o     (latch),
        .oe_n_o      (oe_n),
        .row_addr_o  (row_addr),
        .frame_done_o(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories shared address.
    always @(posedge clk) begin
        if (rd_en) begin
            rdata0 <= mem0[rd_addr];
            rdata1 <= mem1[rd_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one (row, plane) unit: records colour bits at each sclk rise and
    // stops when the oe_n window closes.
    task automatic capture_unit();
        int guard;
        logic prev_sclk, in_win, done;
        logic [5:0] prev_rgb;
        n_sclk = 0; n_latch = 0; win_len = 0; row_during = -1;
        for (int i = 0; i < 64; i++) cap[i] = 6'b0;
        prev_sclk = sclk; prev_rgb = {r0, g0, b0, r1, g1, b1};
        in_win = 0; done = 0; guard = 0;
        while (!done && guard < 3000) begin
            tick();
            guard++;
            if (sclk && !prev_sclk) begin
                if (n_sclk < 64) cap[n_sclk] = {r0, g0, b0, r1, g1, b1};
                if ({r0, g0, b0, r1, g1, b1} != prev_rgb) unstable_cnt++;
                n_sclk++;
            end
            if (latch) n_latch++;
            if (sclk && latch) overlap_cnt++;
            if (!oe_n) begin
                in_win = 1;
                win_len++;
                row_during = int'(row_addr);
            end else if (in_win) begin
                done = 1;
            end
            prev_sclk = sclk;
            prev_rgb  = {r0, g0, b0, r1, g1, b1};
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if ({rd_en, sclk, latch, oe_n, frame_done, r0, g0, b0, r1, g1, b1} !== 11'b00010000000) begin
            $display("FAIL reset_ctrl: got %b expected %b",
                     {rd_en, sclk, latch, oe_n, frame_done, r0, g0, b0, r1, g1, b1}, 11'b00010000000);
        end else pass_cnt++;
        total_cnt++;
        if (rd_addr !== 11'd0 || row_addr !== 5'd0) begin
            $display("FAIL reset_addr: got rd_addr=%h row_addr=%0d expected 0/0", rd_addr, row_addr);
        end else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (rd_en !== 1'b1 || rd_addr !== 11'd0) begin
            $display("FAIL first_read: got rd_en=%b rd_addr=%h expected 1/000", rd_en, rd_addr);
        end else pass_cnt++;
    endtask

    // Row 0: single full-red pixel at column 0 of the upper half.
    task automatic test_red_pixel();
        int bad;
        for (int p = 0; p < 4; p++) begin
            capture_unit();
            bad = 0;
            for (int c = 1; c < 64; c++) if (cap[c] !== 6'b0) bad++;
            total_cnt++;
            if (timeout !== 1'b0 || n_sclk != 64) begin
                $display("FAIL red_sclks plane %0d: got %0d pulses timeout=%b expected 64/0", p, n_sclk, timeout);
            end else pass_cnt++;
            total_cnt++;
            if (cap[0] !== 6'b100000) begin
                $display("FAIL red_col0 plane %0d: got %b expected 100000", p, cap[0]);
            end else pass_cnt++;
            total_cnt++;
            if (bad != 0 || row_during != 0) begin
                $display("FAIL red_rest plane %0d: got %0d nonzero cols row=%0d expected 0/0", p, bad, row_during);
            end else pass_cnt++;
        end
    endtask

    // Row 1: BCM window lengths and the shift/latch sequence ahead of each.
    task automatic test_bcm_timing();
        for (int p = 0; p < 4; p++) begin
            capture_unit();
            total_cnt++;
            if (win_len != (4 << p)) begin
                $display("FAIL bcm_window plane %0d: got %0d cycles expected %0d", p, win_len, 4 << p);
            end else pass_cnt++;
            total_cnt++;
            if (n_latch != 1 || n_sclk != 64 || row_during != 1) begin
                $display("FAIL bcm_seq plane %0d: got latch=%0d sclk=%0d row=%0d expected 1/64/1",
                         p, n_latch, n_sclk, row_during);
            end else pass_cnt++;
        end
        total_cnt++;
        if (overlap_cnt != 0 || unstable_cnt != 0) begin
            $display("FAIL sclk_hygiene: got overlap=%0d unstable=%0d expected 0/0", overlap_cnt, unstable_cnt);
        end else pass_cnt++;
    endtask

    // Row 3: blue pixel of the lower half at column 10.
    task automatic test_blue_lower();
        int bad;
        for (int p = 0; p < 4; p++) capture_unit();
        for (int p = 0; p < 4; p++) begin
            capture_unit();
            bad = 0;
            for (int c = 0; c < 64; c++) if (c != 10 && cap[c] !== 6'b0) bad++;
            total_cnt++;
            if (cap[10] !== 6'b000001 || bad != 0) begin
                $display("FAIL blue_col10 plane %0d: got %b with %0d other nonzero expected 000001/0",
                         p, cap[10], bad);
            end else pass_cnt++;
            total_cnt++;
            if (row_during != 3) begin
                $display("FAIL blue_row plane %0d: got row_addr=%0d expected 3", p, row_during);
            end else pass_cnt++;
        end
    endtask

    // Reset in the middle of row 5, then a clean restart at row 0, plane 0.
    task automatic test_mid_reset();
        int rises, guard, exp_plane;
        logic prev_sclk;
        logic [5:0] exp_rgb;
        for (int p = 0; p < 4; p++) capture_unit();
        rises = 0; guard = 0; prev_sclk = sclk;
        while (rises < 20 && guard < 1000) begin
            tick();
            guard++;
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
        end
        total_cnt++;
        if (rises != 20) begin
            $display("FAIL midreset_reach: got %0d sclk rises expected 20", rises);
        end else pass_cnt++;
        reset = 1'b1;
        mem0[0] = 12'h800;
        tick();
        total_cnt++;
        if ({rd_en, sclk, latch, oe_n, frame_done, r0, g0, b0, r1, g1, b1, row_addr, rd_addr} !==
            {11'b00010000000, 5'd0, 11'd0}) begin
            $display("FAIL midreset_outs: got %b expected %b",
                     {rd_en, sclk, latch, oe_n, frame_done, r0, g0, b0, r1, g1, b1, row_addr, rd_addr},
                     {11'b00010000000, 5'd0, 11'd0});
        end else pass_cnt++;
        tick(); tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if (rd_en !== 1'b1 || rd_addr !== 11'd0) begin
            $display("FAIL midreset_restart: got rd_en=%b rd_addr=%h expected 1/000", rd_en, rd_addr);
        end else pass_cnt++;
`ifdef HUB75_GAMMA_EN
        exp_plane = 1;
`else
        exp_plane = 3;
`endif
        for (int p = 0; p < 4; p++) begin
            capture_unit();
            exp_rgb = (p == exp_plane) ? 6'b100000 : 6'b000000;
            total_cnt++;
            if (cap[0] !== exp_rgb || win_len != (4 << p) || row_during != 0) begin
                $display("FAIL midreset_scan plane %0d: got rgb=%b win=%0d row=%0d expected %b/%0d/0",
                         p, cap[0], win_len, row_during, exp_rgb, 4 << p);
            end else pass_cnt++;
        end
    endtask

    // Frame pacing from a fresh reset.
    task automatic test_frame();
        int n;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < 30000);
        total_cnt++;
        if (n != 26753) begin
            $display("FAIL frame_first: got pulse at cycle %0d expected 26753", n);
        end else pass_cnt++;
        tick();
        n = 1;
        total_cnt++;
        if (frame_done !== 1'b0) begin
            $display("FAIL frame_width: got frame_done=%b expected 0", frame_done);
        end else pass_cnt++;
        while (!frame_done && n < 30000) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n != 26752) begin
            $display("FAIL frame_period: got %0d cycles expected 26752", n);
        end else pass_cnt++;
        capture_unit();
        total_cnt++;
        if (row_during != 0 || timeout !== 1'b0) begin
            $display("FAIL frame_wrap: got row_addr=%0d timeout=%b expected 0/0", row_during, timeout);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        overlap_cnt = 0; unstable_cnt = 0;
        reset = 1'b1;
        rdata0 = 12'h0; rdata1 = 12'h0;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 12'h0;
            mem1[i] = 12'h0;
        end
        mem0[0]      = 12'hF00;
        mem1[11'h0CA] = 12'h00F;

        test_reset();
        test_red_pixel();
        test_bcm_timing();
        test_blue_lower();
        test_mid_reset();
        test_frame();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
